conv_tile_sched: RTL and testbench

CONV_TILE_SCHED -- requirements
Module: conv_tile_sched

---
 rtl/conv_tile_sched_if.sv | 69 ++++++
 rtl/conv_tile_sched.sv | 185 ++++++++++++++++++
 tb/tb_conv_tile_sched.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_tile_sched_if.sv
// Handshake bundle between the layer tile scheduler and its datapath.
// The master side belongs to the scheduler; slave is the datapath view.
interface conv_tile_sched_if #(
  parameter int CW = 16
);
  logic          start;
  logic          done;
  logic          busy;
  logic          out_clear_start;
  logic          out_clear_done;
  logic          in_load_start;
  logic          in_load_done;
  logic          wt_load_start;
  logic          wt_load_done;
  logic          conv_tile_reset;
  logic          conv_computing_start;
  logic          conv_computing_done;
  logic          out_store_start;
  logic          out_store_done;
  logic [CW-1:0] tile_n;
  logic [CW-1:0] tile_m;
  logic [CW-1:0] tile_r;
  logic [CW-1:0] tile_c;
  logic [2:0]    state;

  modport master (
    input  start,
    input  out_clear_done,
    input  in_load_done,
    input  wt_load_done,
    input  conv_computing_done,
    input  out_store_done,
    output done,
    output busy,
    output out_clear_start,
    output in_load_start,
    output wt_load_start,
    output conv_tile_reset,
    output conv_computing_start,
    output out_store_start,
    output tile_n,
    output tile_m,
    output tile_r,
    output tile_c,
    output state
  );

  modport slave (
    output start,
    output out_clear_done,
    output in_load_done,
    output wt_load_done,
    output conv_computing_done,
    output out_store_done,
    input  done,
    input  busy,
    input  out_clear_start,
    input  in_load_start,
    input  wt_load_start,
    input  conv_tile_reset,
    input  conv_computing_start,
    input  out_store_start,
    input  tile_n,
    input  tile_m,
    input  tile_r,
    input  tile_c,
    input  state
  );
endinterface

// File: rtl/conv_tile_sched.sv
// Layer-level tile scheduler: walks n/r/c/m tiles and sequences the
// clear, load, conv and store handshakes for each output tile.
module conv_tile_sched #(
  parameter int CW     = 16,
  parameter int TN_NUM = 4,
  parameter int TM_NUM = 4,
  parameter int TR_NUM = 2,
  parameter int TC_NUM = 2
) (
  input  logic              clk,
  input  logic              rst,
  conv_tile_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_CRST  = 3'd3,
    S_COMP  = 3'd4,
    S_STORE = 3'd5,
    S_NEXT  = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] M_MAX = CW'(TM_NUM - 1);
  localparam logic [CW-1:0] N_MAX = CW'(TN_NUM - 1);
  localparam logic [CW-1:0] R_MAX = CW'(TR_NUM - 1);
  localparam logic [CW-1:0] C_MAX = CW'(TC_NUM - 1);

  state_t        r_state;
  logic          r_start_q;
  logic          r_in_ok;
  logic          r_wt_ok;
  logic          r_done;
  logic          r_busy;
  logic          r_clr;
  logic          r_in;
  logic          r_wt;
  logic          r_crst;
  logic          r_cs;
  logic          r_st;
  logic [CW-1:0] r_n;
  logic [CW-1:0] r_m;
  logic [CW-1:0] r_r;
  logic [CW-1:0] r_c;

  logic w_edge;
  logic w_load_ok;
  logic w_m_last;
  logic w_n_last;
  logic w_r_last;
  logic w_c_last;

  assign w_edge    = bus.start & ~r_start_q;
  assign w_load_ok = (r_in_ok | bus.in_load_done)
                   & (r_wt_ok | bus.wt_load_done);
  assign w_m_last  = (r_m == M_MAX);
  assign w_n_last  = (r_n == N_MAX);
  assign w_r_last  = (r_r == R_MAX);
  assign w_c_last  = (r_c == C_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_start_q <= 1'b0;
      r_in_ok   <= 1'b0;
      r_wt_ok   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_clr     <= 1'b0;
      r_in      <= 1'b0;
      r_wt      <= 1'b0;
      r_crst    <= 1'b0;
      r_cs      <= 1'b0;
      r_st      <= 1'b0;
      r_n       <= '0;
      r_m       <= '0;
      r_r       <= '0;
      r_c       <= '0;
    end else begin
      r_start_q <= bus.start;
      r_done    <= 1'b0;
      r_clr     <= 1'b0;
      r_in      <= 1'b0;
      r_wt      <= 1'b0;
      r_crst    <= 1'b0;
      r_st      <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_clr   <= 1'b1;
            r_n     <= '0;
            r_m     <= '0;
            r_r     <= '0;
            r_c     <= '0;
          end
        end
        S_CLEAR: begin
          if (bus.out_clear_done) begin
            r_state <= S_LOAD;
            r_in    <= 1'b1;
            r_wt    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_load_ok) begin
            r_state <= S_CRST;
            r_crst  <= 1'b1;
            r_in_ok <= 1'b0;
            r_wt_ok <= 1'b0;
          end else begin
            if (bus.in_load_done) r_in_ok <= 1'b1;
            if (bus.wt_load_done) r_wt_ok <= 1'b1;
          end
        end
        S_CRST: begin
          r_state <= S_COMP;
          r_cs    <= 1'b1;
        end
        S_COMP: begin
          if (bus.conv_computing_done) begin
            r_cs <= 1'b0;
            if (w_m_last) begin
              r_state <= S_STORE;
              r_st    <= 1'b1;
            end else begin
              r_state <= S_LOAD;
              r_m     <= r_m + ONE;
              r_in    <= 1'b1;
              r_wt    <= 1'b1;
            end
          end
        end
        S_STORE: begin
          if (bus.out_store_done) r_state <= S_NEXT;
        end
        S_NEXT: begin
          // last tile keeps its indices visible until the next run
          if (w_c_last && w_r_last && w_n_last) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_CLEAR;
            r_clr   <= 1'b1;
            r_m     <= '0;
            if (!w_c_last) begin
              r_c <= r_c + ONE;
            end else begin
              r_c <= '0;
              if (!w_r_last) begin
                r_r <= r_r + ONE;
              end else begin
                r_r <= '0;
                r_n <= r_n + ONE;
              end
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.done                 = r_done;
  assign bus.busy                 = r_busy;
  assign bus.out_clear_start      = r_clr;
  assign bus.in_load_start        = r_in;
  assign bus.wt_load_start        = r_wt;
  assign bus.conv_tile_reset      = r_crst;
  assign bus.conv_computing_start = r_cs;
  assign bus.out_store_start      = r_st;
  assign bus.tile_n               = r_n;
  assign bus.tile_m               = r_m;
  assign bus.tile_r               = r_r;
  assign bus.tile_c               = r_c;
  assign bus.state                = r_state;

endmodule

// File: tb/tb_conv_tile_sched.sv
// Directed bench for conv_tile_sched: default-size instance plus a
// single-tile instance, with 3-cycle done responders.
module tb_conv_tile_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  conv_tile_sched_if #(.CW(16)) ia();
  conv_tile_sched_if #(.CW(16)) ib();

  conv_tile_sched #(.CW(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  conv_tile_sched #(
    .CW(16), .TN_NUM(1), .TM_NUM(1), .TR_NUM(1), .TC_NUM(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  int errs = 0;
  int checks = 0;

  logic auto_a = 1'b0;
  logic m_start = 1'b0;
  logic m_cd = 1'b0;
  logic m_id = 1'b0;
  logic m_wd = 1'b0;
  logic m_kd = 1'b0;
  logic m_sd = 1'b0;
  logic b_start = 1'b0;

  logic ra_cd = 1'b0, ra_id = 1'b0, ra_wd = 1'b0;
  logic ra_kd = 1'b0, ra_sd = 1'b0;
  int ca_cd = 0, ca_id = 0, ca_wd = 0, ca_kd = 0, ca_sd = 0;
  int na_cs = 0, na_clr = 0, na_st = 0, na_done = 0;
  logic a_csq = 1'b0;

  logic rb_cd = 1'b0, rb_id = 1'b0, rb_wd = 1'b0;
  logic rb_kd = 1'b0, rb_sd = 1'b0;
  int cb_cd = 0, cb_id = 0, cb_wd = 0, cb_kd = 0, cb_sd = 0;
  int nb_cs = 0, nb_clr = 0, nb_in = 0, nb_wt = 0;
  int nb_crst = 0, nb_st = 0, nb_done = 0;
  logic b_csq = 1'b0;
  logic [2:0] b_prev = 3'd0;
  int bseq[$];

  assign ia.start               = m_start;
  assign ia.out_clear_done      = auto_a ? ra_cd : m_cd;
  assign ia.in_load_done        = auto_a ? ra_id : m_id;
  assign ia.wt_load_done        = auto_a ? ra_wd : m_wd;
  assign ia.conv_computing_done = auto_a ? ra_kd : m_kd;
  assign ia.out_store_done      = auto_a ? ra_sd : m_sd;

  assign ib.start               = b_start;
  assign ib.out_clear_done      = rb_cd;
  assign ib.in_load_done        = rb_id;
  assign ib.wt_load_done        = rb_wd;
  assign ib.conv_computing_done = rb_kd;
  assign ib.out_store_done      = rb_sd;

  always @(negedge clk) begin
    ra_cd = 1'b0; ra_id = 1'b0; ra_wd = 1'b0;
    ra_kd = 1'b0; ra_sd = 1'b0;
    if (ca_cd != 0) begin ca_cd--; ra_cd = (ca_cd == 0); end
    if (ca_id != 0) begin ca_id--; ra_id = (ca_id == 0); end
    if (ca_wd != 0) begin ca_wd--; ra_wd = (ca_wd == 0); end
    if (ca_kd != 0) begin ca_kd--; ra_kd = (ca_kd == 0); end
    if (ca_sd != 0) begin ca_sd--; ra_sd = (ca_sd == 0); end
    if (ia.out_clear_start) begin ca_cd = 3; na_clr++; end
    if (ia.in_load_start) ca_id = 3;
    if (ia.wt_load_start) ca_wd = 3;
    if (ia.conv_computing_start && !a_csq) begin
      ca_kd = 3; na_cs++;
    end
    if (ia.out_store_start) begin ca_sd = 3; na_st++; end
    if (ia.done) na_done++;
    a_csq = ia.conv_computing_start;
  end

  always @(negedge clk) begin
    rb_cd = 1'b0; rb_id = 1'b0; rb_wd = 1'b0;
    rb_kd = 1'b0; rb_sd = 1'b0;
    if (cb_cd != 0) begin cb_cd--; rb_cd = (cb_cd == 0); end
    if (cb_id != 0) begin cb_id--; rb_id = (cb_id == 0); end
    if (cb_wd != 0) begin cb_wd--; rb_wd = (cb_wd == 0); end
    if (cb_kd != 0) begin cb_kd--; rb_kd = (cb_kd == 0); end
    if (cb_sd != 0) begin cb_sd--; rb_sd = (cb_sd == 0); end
    if (ib.out_clear_start) begin cb_cd = 3; nb_clr++; end
    if (ib.in_load_start) begin cb_id = 3; nb_in++; end
    if (ib.wt_load_start) begin cb_wd = 3; nb_wt++; end
    if (ib.conv_tile_reset) nb_crst++;
    if (ib.conv_computing_start && !b_csq) begin
      cb_kd = 3; nb_cs++;
    end
    if (ib.out_store_start) begin cb_sd = 3; nb_st++; end
    if (ib.done) nb_done++;
    b_csq = ib.conv_computing_start;
    if (ib.state != b_prev) begin
      bseq.push_back(int'(ib.state));
      b_prev = ib.state;
    end
  end

  // {busy, done, clr, in, wt, crst, cs, store}
  function automatic logic [7:0] outs_a();
    return {ia.busy, ia.done, ia.out_clear_start,
            ia.in_load_start, ia.wt_load_start,
            ia.conv_tile_reset, ia.conv_computing_start,
            ia.out_store_start};
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // in = {start, clear_done, in_done, wt_done, comp_done, store_done}
  typedef struct {
    logic [5:0] in;
    logic [2:0] es;
    logic [7:0] eo;
    int         em;
    int         ec;
  } vec_t;

  function automatic vec_t mk(logic [5:0] in, logic [2:0] es,
                              logic [7:0] eo, int em, int ec);
    vec_t v;
    v.in = in; v.es = es; v.eo = eo; v.em = em; v.ec = ec;
    return v;
  endfunction

  task automatic drive(logic [5:0] in);
    m_start = in[5]; m_cd = in[4]; m_id = in[3];
    m_wd = in[2]; m_kd = in[1]; m_sd = in[0];
  endtask

  task automatic load_case(string nm, bit wfirst, int gap);
    logic early;
    early = 1'b0;
    if (gap == 0) begin m_id = 1'b1; m_wd = 1'b1; end
    else if (wfirst) m_wd = 1'b1;
    else m_id = 1'b1;
    @(negedge clk);
    m_id = 1'b0; m_wd = 1'b0;
    for (int i = 0; i < gap; i++) begin
      if (ia.conv_tile_reset || ia.state != 3'd2) early = 1'b1;
      if (i == gap - 1) begin
        if (wfirst) m_id = 1'b1; else m_wd = 1'b1;
      end
      @(negedge clk);
      m_id = 1'b0; m_wd = 1'b0;
    end
    chk({nm, " early_crst"}, early, 0);
    chk({nm, " crst"}, ia.conv_tile_reset, 1);
    chk({nm, " state_crst"}, ia.state, 3);
    @(negedge clk);
    chk({nm, " comp_cs"}, ia.conv_computing_start, 1);
    m_kd = 1'b1;
    @(negedge clk);
    m_kd = 1'b0;
  endtask

  vec_t tv[25];
  int exp_seq[8] = '{1, 2, 3, 4, 5, 6, 7, 0};

  initial begin
    int b0_cs, b0_clr, b0_st, b0_done;
    logic got, bad;

    tv[0]  = mk(6'b100000, 3'd1, 8'b1010_0000, 0, 0);
    tv[1]  = mk(6'b100000, 3'd1, 8'b1000_0000, 0, 0);
    tv[2]  = mk(6'b010000, 3'd2, 8'b1001_1000, 0, 0);
    tv[3]  = mk(6'b000010, 3'd2, 8'b1000_0000, 0, 0);
    tv[4]  = mk(6'b000100, 3'd2, 8'b1000_0000, 0, 0);
    tv[5]  = mk(6'b000000, 3'd2, 8'b1000_0000, 0, 0);
    tv[6]  = mk(6'b001000, 3'd3, 8'b1000_0100, 0, 0);
    tv[7]  = mk(6'b000000, 3'd4, 8'b1000_0010, 0, 0);
    tv[8]  = mk(6'b100000, 3'd4, 8'b1000_0010, 0, 0);
    tv[9]  = mk(6'b000000, 3'd4, 8'b1000_0010, 0, 0);
    tv[10] = mk(6'b000010, 3'd2, 8'b1001_1000, 1, 0);
    tv[11] = mk(6'b001100, 3'd3, 8'b1000_0100, 1, 0);
    tv[12] = mk(6'b000000, 3'd4, 8'b1000_0010, 1, 0);
    tv[13] = mk(6'b000010, 3'd2, 8'b1001_1000, 2, 0);
    tv[14] = mk(6'b001000, 3'd2, 8'b1000_0000, 2, 0);
    tv[15] = mk(6'b000100, 3'd3, 8'b1000_0100, 2, 0);
    tv[16] = mk(6'b000000, 3'd4, 8'b1000_0010, 2, 0);
    tv[17] = mk(6'b000010, 3'd2, 8'b1001_1000, 3, 0);
    tv[18] = mk(6'b001100, 3'd3, 8'b1000_0100, 3, 0);
    tv[19] = mk(6'b000000, 3'd4, 8'b1000_0010, 3, 0);
    tv[20] = mk(6'b000001, 3'd4, 8'b1000_0010, 3, 0);
    tv[21] = mk(6'b000010, 3'd5, 8'b1000_0001, 3, 0);
    tv[22] = mk(6'b000000, 3'd5, 8'b1000_0000, 3, 0);
    tv[23] = mk(6'b000001, 3'd6, 8'b1000_0000, 3, 0);
    tv[24] = mk(6'b000000, 3'd1, 8'b1010_0000, 0, 1);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset state", ia.state, 0);
    chk("reset outs", outs_a(), 0);
    chk("reset tiles",
        ia.tile_n | ia.tile_m | ia.tile_r | ia.tile_c, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      drive(tv[i].in);
      @(negedge clk);
      chk($sformatf("vec%0d state", i), ia.state, tv[i].es);
      chk($sformatf("vec%0d outs", i), outs_a(), tv[i].eo);
      chk($sformatf("vec%0d tile_m", i), ia.tile_m, tv[i].em);
      chk($sformatf("vec%0d tile_c", i), ia.tile_c, tv[i].ec);
    end
    drive(6'b000000);

    m_cd = 1'b1;
    @(negedge clk);
    m_cd = 1'b0;
    chk("ord enter load", ia.state, 2);
    load_case("ord wt_first", 1'b1, 5);
    load_case("ord in_first", 1'b0, 5);
    load_case("ord same", 1'b0, 0);
    chk("ord end state", ia.state, 2);
    chk("ord end tile_m", ia.tile_m, 3);

    rst = 1'b0;
    repeat (2) @(negedge clk);
    auto_a = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    b0_cs = na_cs; b0_clr = na_clr;
    b0_st = na_st; b0_done = na_done;
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    chk("run busy", ia.busy, 1);
    got = 1'b0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk);
      if (ia.done) got = 1'b1;
    end
    chk("run done seen", got, 1);
    chk("run fin state", ia.state, 7);
    chk("run fin busy", ia.busy, 0);
    repeat (4) @(negedge clk);
    chk("run idle", ia.state, 0);
    chk("run done once", ia.done, 0);
    chk("run comp count", na_cs - b0_cs, 64);
    chk("run clear count", na_clr - b0_clr, 16);
    chk("run store count", na_st - b0_st, 16);
    chk("run done count", na_done - b0_done, 1);
    chk("run tile_n", ia.tile_n, 3);
    chk("run tile_r", ia.tile_r, 1);
    chk("run tile_c", ia.tile_c, 1);
    chk("run tile_m", ia.tile_m, 3);

    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk);
      if (ia.state == 3'd4 && ia.tile_n == 16'd1 &&
          ia.tile_r == 16'd0 && ia.tile_c == 16'd1 &&
          ia.tile_m == 16'd2)
        got = 1'b1;
    end
    chk("abort reached tile", got, 1);
    b0_done = na_done;
    #2 rst = 1'b0;
    #1;
    chk("abort async state", ia.state, 0);
    chk("abort async outs", outs_a(), 0);
    chk("abort async tiles",
        ia.tile_n | ia.tile_m | ia.tile_r | ia.tile_c, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ia.state != 3'd0 || outs_a() != 8'd0) bad = 1'b1;
    end
    chk("abort stays idle", bad, 0);
    chk("abort no done", na_done - b0_done, 0);
    m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    chk("restart state", ia.state, 1);
    chk("restart tiles",
        ia.tile_n | ia.tile_m | ia.tile_r | ia.tile_c, 0);

    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bseq.delete();
    @(negedge clk);
    b_start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (ib.done) got = 1'b1;
    end
    chk("single done seen", got, 1);
    repeat (6) @(negedge clk);
    chk("single held start idle", ib.state, 0);
    chk("single seq len", bseq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < bseq.size())
        chk($sformatf("single seq%0d", i), bseq[i], exp_seq[i]);
    end
    chk("single clears", nb_clr, 1);
    chk("single in loads", nb_in, 1);
    chk("single wt loads", nb_wt, 1);
    chk("single crst", nb_crst, 1);
    chk("single comps", nb_cs, 1);
    chk("single stores", nb_st, 1);
    chk("single dones", nb_done, 1);
    b_start = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
